// File: rtl/rgb_mask_unit.sv
// rgb_mask_unit: 16-entry RGB mask memory feeding a per-channel 8-bit pixel ALU.
// Mode=0 stores the incoming pixel as a mask entry; Mode=1 combines the pixel
// with the addressed mask (or with itself for the unary ops) and registers it.
module rgb_mask_unit #(
  parameter logic [23:0] MASK_INIT = 24'hA6A6A6
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Mode,
  input  logic [3:0]  Address,
  input  logic [23:0] RGBin,
  input  logic [2:0]  Op,
  output logic [23:0] RGBout
);

  // Power-up contents match the reset contents so the block behaves the same
  // whether or not a reset has been applied yet.
  logic [23:0] mem [16] = '{default: MASK_INIT};
  logic [23:0] rgb_q = 24'h000000;
  logic [23:0] mask_word;
  logic [23:0] alu_result;

  // One channel of the ALU; channels never share carries or borrows.
  function automatic logic [7:0] chan_op(input logic [2:0] op,
                                         input logic [7:0] x,
                                         input logic [7:0] m);
    logic [8:0] sum;
    logic [7:0] res;
    sum = {1'b0, x} + {1'b0, m};
    res = 8'h00;
    case (op)
      3'b000: res = x & m;
      3'b001: res = x | m;
      3'b010: res = x ^ m;
      3'b011: res = sum[8] ? 8'hFF : sum[7:0];
      3'b100: res = (m > x) ? 8'h00 : (x - m);
      3'b101: res = (x == 8'hFF) ? 8'hFF : (x + 8'd1);
      3'b110: res = (x == 8'h00) ? 8'h00 : (x - 8'd1);
      3'b111: res = {x[6:0], x[7]};
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  // Read the addressed mask entry and evaluate all three channels in parallel.
  always_comb begin
    mask_word  = mem[Address];
    alu_result = 24'h000000;
    alu_result[23:16] = chan_op(Op, RGBin[23:16], mask_word[23:16]);
    alu_result[15:8]  = chan_op(Op, RGBin[15:8],  mask_word[15:8]);
    alu_result[7:0]   = chan_op(Op, RGBin[7:0],   mask_word[7:0]);
  end

  // Mask memory: reset restores every entry; writes only happen in Mode=0.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= MASK_INIT;
      end
    end else if (!Mode) begin
      mem[Address] <= RGBin;
    end
  end

  // Output register: cleared on reset, updated on compute, held on writes.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rgb_q <= 24'h000000;
    end else if (Mode) begin
      rgb_q <= alu_result;
    end
  end

  assign RGBout = rgb_q;

endmodule

// File: tb/tb_rgb_mask_unit.sv
// tb_rgb_mask_unit: directed vectors for rgb_mask_unit. The driver pushes the
// hand-computed expected output for every edge into a queue; an independent
// monitor pops one entry after each rising edge and compares it.
module tb_rgb_mask_unit;

  logic        CLK;
  logic        RSTn;
  logic        Mode;
  logic [3:0]  Address;
  logic [23:0] RGBin;
  logic [2:0]  Op;
  logic [23:0] RGBout;

  typedef struct {
    string       name;
    logic [23:0] exp;
  } item_t;

  item_t       sbQueue[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] lastExp = 24'h000000;

  rgb_mask_unit dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .Mode    (Mode),
    .Address (Address),
    .RGBin   (RGBin),
    .Op      (Op),
    .RGBout  (RGBout)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one popped expectation against the live output.
  task automatic checkOutput(input item_t it);
    checks++;
    if (RGBout !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s: got %06h expected %06h", it.name, RGBout, it.exp);
    end else begin
      $display("[TB] ok   %s: %06h", it.name, RGBout);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and queue its expected result.
  task automatic applyStimulus(input string name, input logic rstn, input logic mode,
                               input logic [3:0] addr, input logic [23:0] rgb,
                               input logic [2:0] op, input logic [23:0] exp);
    item_t it;
    @(negedge CLK);
    RSTn    = rstn;
    Mode    = mode;
    Address = addr;
    RGBin   = rgb;
    Op      = op;
    it.name = name;
    it.exp  = exp;
    lastExp = exp;
    sbQueue.push_back(it);
    @(posedge CLK);
  endtask

  // Monitor: output is valid one edge after inputs are sampled.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
    end
  end

  // Directed stimulus with expected values worked out by hand.
  initial begin
    RSTn = 1'b1; Mode = 1'b1; Address = 4'd0; RGBin = 24'h0; Op = 3'b000;

    // Power-up contents without reset: OR with zero exposes the mask.
    applyStimulus("powerup_mask", 1'b1, 1'b1, 4'd10, 24'h000000, 3'b001, 24'hA6A6A6);

    applyStimulus("reset",        1'b0, 1'b1, 4'd10, 24'h81C342, 3'b000, 24'h000000);
    applyStimulus("and",          1'b1, 1'b1, 4'd10, 24'h81C342, 3'b000, 24'h808202);
    applyStimulus("or",           1'b1, 1'b1, 4'd10, 24'h81C342, 3'b001, 24'hA7E7E6);
    applyStimulus("xor",          1'b1, 1'b1, 4'd10, 24'h81C342, 3'b010, 24'h2765E4);
    applyStimulus("sat_add",      1'b1, 1'b1, 4'd10, 24'h81C342, 3'b011, 24'hFFFFE8);
    applyStimulus("sat_sub",      1'b1, 1'b1, 4'd10, 24'h81C342, 3'b100, 24'h001D00);
    applyStimulus("inc",          1'b1, 1'b1, 4'd10, 24'h81C342, 3'b101, 24'h82C443);
    applyStimulus("dec",          1'b1, 1'b1, 4'd10, 24'h81C342, 3'b110, 24'h80C241);
    applyStimulus("rotl",         1'b1, 1'b1, 4'd10, 24'h81C342, 3'b111, 24'h038784);
    applyStimulus("inc_sat",      1'b1, 1'b1, 4'd10, 24'hFF0080, 3'b101, 24'hFF0181);
    applyStimulus("dec_sat",      1'b1, 1'b1, 4'd10, 24'hFF0080, 3'b110, 24'hFE007F);

    // Write holds the output at the previous result.
    applyStimulus("write_hold",   1'b1, 1'b0, 4'd3,  24'h0F0F0F, 3'b000, lastExp);
    applyStimulus("read_or",      1'b1, 1'b1, 4'd3,  24'hF0F0F0, 3'b001, 24'hFFFFFF);
    applyStimulus("read_and",     1'b1, 1'b1, 4'd3,  24'hF0F0F0, 3'b000, 24'h000000);
    applyStimulus("untouched4",   1'b1, 1'b1, 4'd4,  24'hF0F0F0, 3'b000, 24'hA0A0A0);

    // Reset mid-stream restores the mask and clears the output.
    applyStimulus("reset_mid",    1'b0, 1'b1, 4'd3,  24'hF0F0F0, 3'b011, 24'h000000);
    applyStimulus("mask_restore", 1'b1, 1'b1, 4'd3,  24'h000000, 3'b001, 24'hA6A6A6);

    // Let the monitor drain, bounded so the bench always ends.
    for (int i = 0; i < 20 && sbQueue.size() > 0; i++) @(posedge CLK);
    #2;
    if (sbQueue.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d pending expected 0", sbQueue.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
